multisim_push_buffer: RTL and testbench
=======================================

Name: multisim_push_buffer

Overview:
- Elastic FIFO stage directly upstream of the multisim server push stage.
- Decouples the DUT-side producer from server back-pressure: the server stage drops its ready for one or more cycles whenever its DPI push reports the server full.
- Adds occupancy, high-watermark and stall statistics for debugging multisim throughput.
- Output side connects straight to the push stage's valid/ready/data inputs.

Parameters:
- DATA_WIDTH, 64, payload width in bits.
- DEPTH, 8, number of entries; power of two, >= 2.
- ALMOST_FULL_THRESH, DEPTH-2, level at or above which almost_full asserts; range 1..DEPTH.

Ports:
- clk  input  1  single clock; all state on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- in_vld  input  1  producer data valid.
- in_rdy  output  1  buffer can accept; equals !full.
- in_data  input  DATA_WIDTH  producer payload.
- out_vld  output  1  buffer non-empty; feeds the push stage's data_vld.
- out_rdy  input  1  from the push stage's data_rdy.
- out_data  output  DATA_WIDTH  head entry; feeds the push stage's data.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  output  1  level >= ALMOST_FULL_THRESH.
- max_level  output  $clog2(DEPTH)+1  high watermark of level since reset.
- stall_cycles  output  32  count of cycles with out_vld=1 and out_rdy=0; saturates at 2^32-1.

Behaviour:
- Reset (rst_n=0, asynchronous): rd_ptr=wr_ptr=0, level=0, out_vld=0, in_rdy=1, almost_full=0, max_level=0, stall_cycles=0.
  - Storage array is not reset.
  - out_data is don't-care while out_vld=0.
- Push: in_vld && in_rdy at a posedge. Writes mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop: out_vld && out_rdy at a posedge. rd_ptr increments modulo DEPTH.
- Level update:
  - push only: level+1.
  - pop only: level-1.
  - both: unchanged.
- No fall-through: data pushed at edge N is first visible on out_vld/out_data after edge N, i.e. in cycle N+1. Minimum latency is 1 cycle.
- out_data = mem[rd_ptr]. It is stable while out_vld=1 and out_rdy=0; the push stage samples it on handshake.
- in_rdy, out_vld and almost_full are decoded from registered level only. There is no combinational path from out_rdy to in_rdy, or from in_vld to out_vld.
- Full (level=DEPTH):
  - in_rdy=0, so a push in the same cycle as a pop is not accepted.
  - in_rdy returns to 1 the cycle after a pop.
- Empty (level=0): out_vld=0, so no pop can occur regardless of out_rdy.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from level, not from pointer compare.
- max_level is updated each cycle to max(max_level, next level). It never decreases except on reset.
- stall_cycles increments on each posedge where out_vld=1 and out_rdy=0, saturating at 32'hFFFF_FFFF.
- Producer contract: in_data must be held stable while in_vld=1 and in_rdy=0; a violation is flagged by an assertion.
  - Bench checker: in_vld must not drop before handshake.
- Reset mid-operation: all contents are discarded; outputs return to reset values immediately (asynchronously); no partial entry survives.
- Simulation-only assertions:
  - level never exceeds DEPTH.
  - No pop when empty.
  - No push when full.

Test Plan:
- Reset then single push 0xA5 with out_rdy=1 -> out_vld=1 one cycle later with out_data=0xA5; popped next edge; level returns 0; stall_cycles=0.
- DEPTH=8, out_rdy=0, push 10 words 1..10 with in_vld held -> 8 accepted; in_rdy=0 from cycle 9; level=8; almost_full=1 from level 6; max_level=8; stall_cycles increments every cycle out_vld=1.
- From full, out_rdy=1 for one cycle -> word 1 popped; in_rdy=1 next cycle; word 9 accepted; draining yields 2..9 in order, then 10.
- Continuous push and pop each cycle, 20 words, pointers wrap twice -> level constant at 1 after first cycle; data order preserved; max_level=1.
- out_rdy toggled 1,0,0,1 pattern mimicking server back-pressure, 16 random words -> output sequence equals input sequence; stall_cycles equals counted out_vld&&!out_rdy cycles.
- Assert rst_n low mid-stream with level=5 -> level=0, out_vld=0, in_rdy=1, max_level=0, stall_cycles=0 immediately; first post-reset push is the first word observed.

Source files
------------

// File: rtl/multisim_push_buffer.sv
// Elastic FIFO ahead of the multisim server push stage, with occupancy,
// high-watermark and back-pressure stall statistics.
module multisim_push_buffer #(
    parameter int unsigned DATA_WIDTH         = 64,
    parameter int unsigned DEPTH              = 8,
    parameter int unsigned ALMOST_FULL_THRESH = DEPTH - 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         almost_full,
    output logic [$clog2(DEPTH):0]       max_level,
    output logic [31:0]                  stall_cycles
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [LVL_W-1:0]      max_level_q, max_level_d;
    logic [31:0]           stall_q, stall_d;
    logic                  in_rdy_q, in_rdy_d;
    logic                  out_vld_q, out_vld_d;
    logic                  afull_q, afull_d;
    logic                  push_c, pop_c;

    assign push_c = in_vld && in_rdy_q;
    assign pop_c  = out_vld_q && out_rdy;

    // Flags are registered copies of the next level so no input reaches them combinationally
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        level_d     = level_q;
        stall_d     = stall_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        max_level_d = (level_d > max_level_q) ? level_d : max_level_q;
        if (out_vld_q && !out_rdy && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
        in_rdy_d  = (level_d != LVL_W'(DEPTH));
        out_vld_d = (level_d != LVL_W'(0));
        afull_d   = (level_d >= LVL_W'(ALMOST_FULL_THRESH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            max_level_q <= '0;
            stall_q     <= '0;
            in_rdy_q    <= 1'b1;
            out_vld_q   <= 1'b0;
            afull_q     <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            max_level_q <= max_level_d;
            stall_q     <= stall_d;
            in_rdy_q    <= in_rdy_d;
            out_vld_q   <= out_vld_d;
            afull_q     <= afull_d;
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_rdy       = in_rdy_q;
    assign out_vld      = out_vld_q;
    assign almost_full  = afull_q;
    assign out_data     = mem_q[rd_ptr_q];
    assign level        = level_q;
    assign max_level    = max_level_q;
    assign stall_cycles = stall_q;

    a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
        level_q <= LVL_W'(DEPTH));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        pop_c |-> (level_q != LVL_W'(0)));
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        push_c |-> (level_q != LVL_W'(DEPTH)));
    a_producer_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (in_vld && !in_rdy_q) |=> (in_vld && $stable(in_data)));

endmodule

// File: tb/tb_multisim_push_buffer.sv
// Directed bench for multisim_push_buffer (DEPTH=8, almost-full at 6).
module tb_multisim_push_buffer;
    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_vld;
    logic          in_rdy;
    logic [DW-1:0] in_data;
    logic          out_vld;
    logic          out_rdy;
    logic [DW-1:0] out_data;
    logic [3:0]    level;
    logic          almost_full;
    logic [3:0]    max_level;
    logic [31:0]   stall_cycles;

    int checks = 0;
    int errors = 0;

    multisim_push_buffer #(.DATA_WIDTH(DW), .DEPTH(8), .ALMOST_FULL_THRESH(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vld       (in_vld),
        .in_rdy       (in_rdy),
        .in_data      (in_data),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_data     (out_data),
        .level        (level),
        .almost_full  (almost_full),
        .max_level    (max_level),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        in_data = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] q[$];
        logic [DW-1:0] src[$];
        int            got;
        int            stall_exp;
        int            cyc;
        logic          acc;
        logic          mvld;
        logic [3:0]    pat;

        // Reset state
        do_reset();
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd1);
        chk("rst_afull", 64'(almost_full), 64'd0);
        chk("rst_max", 64'(max_level), 64'd0);
        chk("rst_stall", 64'(stall_cycles), 64'd0);

        // Single word, one-cycle latency
        out_rdy = 1'b1;
        in_vld  = 1'b1;
        in_data = 64'hA5;
        chk("t1_no_fallthrough", 64'(out_vld), 64'd0);
        step();
        in_vld = 1'b0;
        chk("t1_vld", 64'(out_vld), 64'd1);
        chk("t1_data", out_data, 64'hA5);
        chk("t1_level1", 64'(level), 64'd1);
        step();
        chk("t1_level0", 64'(level), 64'd0);
        chk("t1_vld0", 64'(out_vld), 64'd0);
        chk("t1_stall", 64'(stall_cycles), 64'd0);
        chk("t1_max", 64'(max_level), 64'd1);

        // Fill to full with the consumer stalled
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 64'(i);
            step();
            chk("t2_level", 64'(level), 64'(i));
            chk("t2_afull", 64'(almost_full), 64'(i >= 6));
        end
        chk("t2_in_rdy_full", 64'(in_rdy), 64'd0);
        in_data = 64'd9;
        step();
        step();
        chk("t2_level_held", 64'(level), 64'd8);
        chk("t2_in_rdy_held", 64'(in_rdy), 64'd0);
        chk("t2_max", 64'(max_level), 64'd8);
        chk("t2_stall", 64'(stall_cycles), 64'd9);
        chk("t2_head", out_data, 64'd1);

        // One pop from full, push blocked that same edge
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        chk("t3_level7", 64'(level), 64'd7);
        chk("t3_in_rdy", 64'(in_rdy), 64'd1);
        chk("t3_stall", 64'(stall_cycles), 64'd9);
        chk("t3_head2", out_data, 64'd2);
        step();
        chk("t3_word9_in", 64'(level), 64'd8);
        chk("t3_stall2", 64'(stall_cycles), 64'd10);
        in_data = 64'd10;
        out_rdy = 1'b1;
        for (int k = 2; k <= 10; k++) begin
            chk("t3_drain_vld", 64'(out_vld), 64'd1);
            chk("t3_drain_data", out_data, 64'(k));
            acc = in_vld && in_rdy;
            step();
            if (acc) in_vld = 1'b0;
        end
        chk("t3_empty_level", 64'(level), 64'd0);
        chk("t3_empty_vld", 64'(out_vld), 64'd0);
        chk("t3_max", 64'(max_level), 64'd8);

        // Streaming push+pop every cycle, pointers wrap
        do_reset();
        out_rdy = 1'b1;
        in_vld  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 64'(100 + i);
            step();
            chk("t4_level", 64'(level), 64'd1);
            chk("t4_data", out_data, 64'(100 + i));
        end
        in_vld = 1'b0;
        step();
        chk("t4_level_end", 64'(level), 64'd0);
        chk("t4_max", 64'(max_level), 64'd1);

        // Server back-pressure pattern 1,0,0,1 against a queue model
        do_reset();
        pat = 4'b1001;
        q.delete();
        src.delete();
        for (int i = 0; i < 16; i++) src.push_back({$urandom, $urandom});
        got = 0;
        stall_exp = 0;
        cyc = 0;
        in_vld = 1'b0;
        while (got < 16 && cyc < 300) begin
            out_rdy = pat[cyc % 4];
            if (src.size() > 0) begin
                in_vld  = 1'b1;
                in_data = src[0];
            end else begin
                in_vld = 1'b0;
            end
            mvld = (q.size() > 0);
            chk("t5_vld", 64'(out_vld), 64'(mvld));
            chk("t5_rdy", 64'(in_rdy), 64'(q.size() < 8));
            if (mvld) chk("t5_data", out_data, q[0]);
            if (mvld && !out_rdy) stall_exp++;
            acc = in_vld && (q.size() < 8);
            step();
            if (mvld && out_rdy) begin
                void'(q.pop_front());
                got++;
            end
            if (acc) q.push_back(src.pop_front());
            cyc++;
        end
        chk("t5_all_out", 64'(got), 64'd16);
        chk("t5_stall", 64'(stall_cycles), 64'(stall_exp));

        // Asynchronous reset mid-stream at level 5
        in_vld  = 1'b1;
        out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = 64'(200 + i);
            step();
        end
        in_vld = 1'b0;
        chk("t6_level5", 64'(level), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_level", 64'(level), 64'd0);
        chk("t6_vld", 64'(out_vld), 64'd0);
        chk("t6_in_rdy", 64'(in_rdy), 64'd1);
        chk("t6_max", 64'(max_level), 64'd0);
        chk("t6_stall", 64'(stall_cycles), 64'd0);
        step();
        rst_n   = 1'b1;
        in_vld  = 1'b1;
        in_data = 64'hBEEF;
        step();
        in_vld = 1'b0;
        chk("t6_first_vld", 64'(out_vld), 64'd1);
        chk("t6_first_data", out_data, 64'hBEEF);
        chk("t6_first_level", 64'(level), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
